// File: rtl/serial_sub_if.sv
// Handshake/data bundle for serial_sub.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf
  );
  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf
  );
`else
  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out
  );
  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out
  );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor, one bit per cycle, LSB first.
// Optional signed-overflow flag under SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int N = 32
) (
  input logic       clk,
  input logic       rst_n,
  serial_sub_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          b_out_q, b_out_d;
`ifdef SERIAL_SUB_OVF_EN
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          ovf_q, ovf_d;
`endif

  logic busy, done;
  logic run_st, accept, last_bit;
  logic a_i, b_i, d_bit, br_nx;

  assign run_st   = (state_q == S_RUN);
  assign accept   = bus.start && !run_st;
  assign last_bit = run_st && (cnt_q == CW'(N - 1));

  assign a_i   = a_q[0];
  assign b_i   = b_q[0];
  assign d_bit = a_i ^ b_i ^ br_q;
  assign br_nx = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    b_out_d = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    unique case (1'b1)
      accept: begin
        a_d   = bus.a;
        b_d   = bus.b;
        br_d  = bus.b_in;
        cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = bus.a[N-1];
        b_msb_d = bus.b[N-1];
`endif
      end
      run_st: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nx;
        diff_d = {d_bit, diff_q[N-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // final bit: d_bit lands in diff[N-1]
        if (last_bit) begin
          b_out_d = br_nx;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d = (a_msb_q != b_msb_q) &&
                  (d_bit != a_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      b_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      b_out_q <= b_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
